// File: rtl/c432_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : c432_key_loader_if
// Description : Bit-serial key delivery handshake (start pulse, data bit,
//               valid/ready) between a key source and the c432 key loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface c432_key_loader_if;
    logic key_start;
    logic key_in;
    logic key_valid;
    logic key_ready;

    // Key source side
    modport master (
        output key_start,
        output key_in,
        output key_valid,
        input  key_ready
    );

    // Loader side
    modport slave (
        input  key_start,
        input  key_in,
        input  key_valid,
        output key_ready
    );
endinterface
`default_nettype wire

// File: rtl/c432_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : c432_key_loader
// Description : Receives a 37-bit unlock key LSB first plus an even-parity
//               bit, and commits it to a stable parallel register feeding the
//               locked c432 key inputs (bits 0..3 -> p1..p4, 4..36 -> X_1..X_33)
//               only when parity checks out.
// Revision    : 1.0 - initial release
// ============================================================================
module c432_key_loader #(
    parameter int KEY_W = 37,
    parameter int CNT_W = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    c432_key_loader_if.slave      bus,
    output logic [KEY_W-1:0]      key_out,
    output logic                  key_loaded,
    output logic                  key_done,
    output logic                  key_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Counter value at which the incoming bit is the parity bit
    localparam logic [CNT_W-1:0] c_CNT_PARITY = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   w_shadow_nxt;
    logic               r_parity;
    logic               w_parity_nxt;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   w_key_nxt;
    logic               r_loaded;
    logic               w_loaded_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_ready;
    logic               w_accept;

    // Ready is decoded straight from the state register, so it is glitch-free
    assign w_ready       = (r_state == ST_SHIFT);
    assign w_accept      = bus.key_valid && w_ready;
    assign bus.key_ready = w_ready;

    assign key_out    = r_key;
    assign key_loaded = r_loaded;
    assign key_done   = r_done;
    assign key_err    = r_err;

    // State and datapath registers; reset clears everything including the committed key
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_parity <= 1'b0;
            r_key    <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_parity <= w_parity_nxt;
            r_key    <= w_key_nxt;
            r_loaded <= w_loaded_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and datapath update: shift into the shadow, commit only on parity pass
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_parity_nxt = r_parity;
        w_key_nxt    = r_key;
        w_loaded_nxt = r_loaded;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;

        case (r_state)
            ST_IDLE: begin
                if (bus.key_start) begin
                    w_state_nxt  = ST_SHIFT;
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = '0;
                    w_err_nxt    = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (r_cnt > c_CNT_PARITY) begin
                    // Counter escaped its legal range: abandon the load
                    w_state_nxt = ST_IDLE;
                end else if (bus.key_start) begin
                    // Restart; the bit presented alongside the start is dropped
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = '0;
                    w_err_nxt    = 1'b0;
                end else if (w_accept) begin
                    if (r_cnt == c_CNT_PARITY) begin
                        w_parity_nxt = bus.key_in;
                        w_state_nxt  = ST_CHECK;
                    end else begin
                        w_shadow_nxt[r_cnt] = bus.key_in;
                        w_cnt_nxt           = r_cnt + c_CNT_ONE;
                    end
                end
            end

            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                if (^{r_shadow, r_parity} == 1'b0) begin
                    w_key_nxt    = r_shadow;
                    w_loaded_nxt = 1'b1;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
